uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Receive-side companion to the CPU's UART transmit path.
- Drains bytes from the UART receive register (uart data-out / rx_valid / read-enable strobe) and stores them in a FIFO.
- Presents the bytes to the data_path MMIO read port as a first-word-fall-through queue with occupancy and sticky-overrun status.
- Sits in top between the uart instance and data_path, replacing the direct rx_data/rx_valid/rx_re wiring.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock (100 MHz)
- resetn  in  1  asynchronous active-low reset
- uart_rx_data  in  8  received byte from the uart receive register
- uart_rx_valid  in  1  uart holds an unread byte
- uart_rx_re  out  1  one-cycle read strobe to the uart; clears its valid
- cpu_rx_re  in  1  CPU pop strobe, one cycle per byte
- cpu_rx_data  out  8  FIFO head byte
- cpu_rx_valid  out  1  FIFO not empty
- cpu_rx_count  out  CNT_W  bytes currently stored, 0..DEPTH
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- clr_overrun  in  1  clears overrun
- cpu_tx_data  in  8  CPU transmit byte (pass-through or arbitrated)
- cpu_tx_we  in  1  CPU transmit write strobe
- uart_tx_busy  in  1  uart transmitter busy
- uart_tx_data  out  8  byte to the uart transmitter
- uart_tx_we  out  1  write strobe to the uart transmitter

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, count 0, overrun 0, FSM in S_IDLE.
  - Reset is honoured mid-transfer; any in-flight byte is discarded.
- Capture FSM states: S_IDLE, S_ACK, S_HOLD.
  - S_IDLE: on uart_rx_valid=1, sample uart_rx_data that same edge.
    - If the FIFO is not full, or a CPU pop occurs on the same edge, push the byte.
    - Otherwise set overrun=1 and drop the byte.
    - Go to S_ACK.
  - S_ACK: uart_rx_re=1 for exactly this one cycle (registered output). Go to S_HOLD.
  - S_HOLD: wait while uart_rx_valid=1, then go to S_IDLE. This guards against double capture of the same byte.
  - Minimum spacing between captures: 3 cycles.
- FIFO:
  - Read/write pointers are CNT_W bits wide and wrap modulo 2*DEPTH.
  - Full when the pointer MSBs differ and the lower bits are equal.
  - cpu_rx_data shows the head combinationally from storage; it is 8'h00 when empty.
  - Latency: a byte pushed at edge N gives cpu_rx_valid=1 and correct cpu_rx_data after edge N.
  - cpu_rx_re while empty: ignored, no pointer change.
  - Push and pop on the same edge: both take effect and count is unchanged. This holds when full (no overrun) and when empty-with-push (pop ignored, count becomes 1).
  - cpu_rx_count is registered: +1 on push only, -1 on pop only.
- overrun:
  - Set has priority over clr_overrun on the same edge.
  - Remains set until cleared or reset.
- Transmit path with echo off: uart_tx_data=cpu_tx_data and uart_tx_we=cpu_tx_we, combinational.

Optional Feature:
- Macro UART_RX_ECHO_EN.
- When defined:
  - Every pushed byte is also loaded into echo_reg and sets echo_pending. A newer byte overwrites a pending one.
  - cpu_tx_we has absolute priority and is passed straight through.
  - Otherwise, when echo_pending=1 and uart_tx_busy=0 and cpu_tx_we=0, the block registers a one-cycle uart_tx_we=1 with uart_tx_data=echo_reg and clears echo_pending.
  - Dropped (overrun) bytes are not echoed.
- When undefined: no echo logic; transmit path is pure pass-through.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (S_IDLE, S_ACK, S_HOLD);
  - the default DEPTH constant;
  - the NULL_BYTE=8'h00 constant.
- Sub-module sync_fifo: parameterised storage, pointers, full/empty and count. The capture FSM and echo logic stay in uart_rx_buffer.

Test Plan:
- Single byte: reset, then uart_rx_valid=1 with data 8'h41, dropped when uart_rx_re seen.
  - uart_rx_re pulses exactly once, 1 cycle after capture.
  - cpu_rx_valid=1, cpu_rx_data=8'h41, count=1.
  - A pop gives count=0 and cpu_rx_data=8'h00.
- Fill: push 16 bytes 8'h30..8'h3F with no pops.
  - count=16; a 17th byte 8'h7A sets overrun=1 and is dropped.
  - Pops return 8'h30..8'h3F in order; clr_overrun clears the flag.
- Full plus simultaneous event: with FIFO full, present byte 8'h55 while cpu_rx_re=1 on the capture edge.
  - overrun stays 0, count stays 16, last pop-out after draining is 8'h55.
- Stuck valid: hold uart_rx_valid=1 for 10 cycles with 8'h21.
  - Exactly one push and one uart_rx_re pulse.
- Reset mid-operation: assert resetn=0 asynchronously while in S_ACK with 5 bytes stored.
  - Outputs go to 0 immediately and count=0.
  - After release, the FSM accepts a new byte 8'h42.
- Echo (with UART_RX_ECHO_EN): receive 8'h68 while cpu_tx_we=1 (8'h2A) and uart_tx_busy=0.
  - 8'h2A goes out first.
  - Once busy drops, a single uart_tx_we pulse carries 8'h68.
  - Without the macro, uart_tx_we mirrors cpu_tx_we only.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared types and constants for the UART receive buffer.
//   rx_state_t    : capture FSM states (S_IDLE, S_ACK, S_HOLD)
//   DEFAULT_DEPTH : default FIFO depth
//   NULL_BYTE     : value shown on the read port when the FIFO is empty
package uart_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } rx_state_t;

    localparam int         DEFAULT_DEPTH = 16;
    localparam logic [7:0] NULL_BYTE     = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- first-word-fall-through byte FIFO with occupancy count.
// Ports:
//   clk, resetn       : clock, asynchronous active-low reset
//   push, push_data   : write request and byte
//   pop               : read request (ignored while empty)
//   head              : current head byte, NULL_BYTE when empty
//   full, empty       : status flags
//   count             : registered occupancy, 0..DEPTH
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [CNT_W-1:0] wptr;
    logic [CNT_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[CNT_W-1] != rptr[CNT_W-1]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A full FIFO is never empty, so a same-edge pop frees the slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);

    assign head = empty ? NULL_BYTE : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + CNT_W'(1);
            if (pop_ok)
                rptr <= rptr + CNT_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer -- drains the UART receive register into a FIFO and presents
// it to the CPU as a first-word-fall-through queue.
// Ports:
//   clk, resetn                    : clock, asynchronous active-low reset
//   uart_rx_data/valid, uart_rx_re : UART receive register handshake
//   cpu_rx_re, cpu_rx_data/valid   : CPU pop strobe and FIFO head
//   cpu_rx_count                   : bytes stored
//   overrun, clr_overrun           : sticky drop flag and its clear
//   cpu_tx_data/we, uart_tx_busy   : CPU transmit side
//   uart_tx_data/we                : to the UART transmitter
// Build option UART_RX_ECHO_EN: echo every stored byte back to the
// transmitter when it is idle; CPU writes always win. Without it the
// transmit path is a plain pass-through.
module uart_rx_buffer
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_valid,
    output logic             uart_rx_re,
    input  logic             cpu_rx_re,
    output logic [7:0]       cpu_rx_data,
    output logic             cpu_rx_valid,
    output logic [CNT_W-1:0] cpu_rx_count,
    output logic             overrun,
    input  logic             clr_overrun,
    input  logic [7:0]       cpu_tx_data,
    input  logic             cpu_tx_we,
    input  logic             uart_tx_busy,
    output logic [7:0]       uart_tx_data,
    output logic             uart_tx_we
);

    rx_state_t state;
    logic      capture;
    logic      push;
    logic      drop;
    logic      full;
    logic      empty;

    // Sample happens on the edge that leaves S_IDLE; push/drop are decided
    // from the FIFO state on that same edge.
    assign capture = (state == S_IDLE) && uart_rx_valid;
    assign push    = capture && (!full || cpu_rx_re);
    assign drop    = capture && full && !cpu_rx_re;

    sync_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (uart_rx_data),
        .pop       (cpu_rx_re),
        .head      (cpu_rx_data),
        .full      (full),
        .empty     (empty),
        .count     (cpu_rx_count)
    );

    assign cpu_rx_valid = !empty;

    // S_HOLD waits for the UART to drop valid so one byte is never taken twice.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            uart_rx_re <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (uart_rx_valid) begin
                        state      <= S_ACK;
                        uart_rx_re <= 1'b1;
                    end
                end
                S_ACK: begin
                    state      <= S_HOLD;
                    uart_rx_re <= 1'b0;
                end
                S_HOLD: begin
                    if (!uart_rx_valid)
                        state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    uart_rx_re <= 1'b0;
                end
            endcase
        end
    end

    // Setting wins over a same-edge clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end

`ifdef UART_RX_ECHO_EN
    logic [7:0] echo_reg;
    logic [7:0] echo_data;
    logic       echo_pending;
    logic       echo_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            echo_reg     <= NULL_BYTE;
            echo_data    <= NULL_BYTE;
            echo_pending <= 1'b0;
            echo_we      <= 1'b0;
        end else begin
            echo_we <= 1'b0;
            // A CPU write landing on the echo strobe cycle masks it; retry.
            if (echo_we && cpu_tx_we)
                echo_pending <= 1'b1;
            if (echo_pending && !uart_tx_busy && !cpu_tx_we) begin
                echo_we      <= 1'b1;
                echo_data    <= echo_reg;
                echo_pending <= 1'b0;
            end
            // Listed last: a fresh byte overrides anything issued above.
            if (push) begin
                echo_reg     <= uart_rx_data;
                echo_pending <= 1'b1;
            end
        end
    end

    assign uart_tx_we   = cpu_tx_we | echo_we;
    assign uart_tx_data = cpu_tx_we ? cpu_tx_data :
                          (echo_we ? echo_data : NULL_BYTE);
`else
    logic unused_tx_busy;
    assign unused_tx_busy = uart_tx_busy;

    assign uart_tx_we   = cpu_tx_we;
    assign uart_tx_data = cpu_tx_data;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer -- directed self-checking bench for uart_rx_buffer.
// Inputs change 1 ns after a rising edge; outputs are read there too.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_valid = 1'b0;
    logic       uart_rx_re;
    logic       cpu_rx_re = 1'b0;
    logic [7:0] cpu_rx_data;
    logic       cpu_rx_valid;
    logic [4:0] cpu_rx_count;
    logic       overrun;
    logic       clr_overrun = 1'b0;
    logic [7:0] cpu_tx_data = 8'h00;
    logic       cpu_tx_we = 1'b0;
    logic       uart_tx_busy = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_we;

    int compared = 0;
    int mismatched = 0;
    int re_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;

    uart_rx_buffer #(.DEPTH(16), .CNT_W(5)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_re    (uart_rx_re),
        .cpu_rx_re     (cpu_rx_re),
        .cpu_rx_data   (cpu_rx_data),
        .cpu_rx_valid  (cpu_rx_valid),
        .cpu_rx_count  (cpu_rx_count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun),
        .cpu_tx_data   (cpu_tx_data),
        .cpu_tx_we     (cpu_tx_we),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_we    (uart_tx_we)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (uart_rx_re) re_cnt++;
        if (uart_tx_we) begin
            tx_cnt++;
            tx_last = uart_tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART model: hold valid until the read strobe appears, then let the
    // capture FSM return to idle.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (uart_rx_re) begin
                ok = 1'b1;
                break;
            end
        end
        uart_rx_valid = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL send_timeout: no uart_rx_re for byte %02h, got 0 want 1", b);
        end
        tick(2);
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = cpu_rx_data;
        cpu_rx_re = 1'b1;
        tick(1);
        cpu_rx_re = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #12;
        compared++; if (uart_rx_re !== 1'b0) begin mismatched++; $display("FAIL reset_rx_re: got %b want 0", uart_rx_re); end
        compared++; if (cpu_rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", cpu_rx_valid); end
        compared++; if (cpu_rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %02h want 00", cpu_rx_data); end
        compared++; if (cpu_rx_count !== 5'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", cpu_rx_count); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        compared++; if (uart_tx_we !== 1'b0) begin mismatched++; $display("FAIL reset_tx_we: got %b want 0", uart_tx_we); end
        @(negedge clk);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_single;
        logic [7:0] b;
        int r0;
        r0 = re_cnt;
        uart_rx_data  = 8'h41;
        uart_rx_valid = 1'b1;
        tick(1);
        compared++; if (uart_rx_re !== 1'b1) begin mismatched++; $display("FAIL single_re_after_capture: got %b want 1", uart_rx_re); end
        compared++; if (cpu_rx_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want 1", cpu_rx_valid); end
        compared++; if (cpu_rx_data !== 8'h41) begin mismatched++; $display("FAIL single_data: got %02h want 41", cpu_rx_data); end
        compared++; if (cpu_rx_count !== 5'd1) begin mismatched++; $display("FAIL single_count: got %0d want 1", cpu_rx_count); end
        uart_rx_valid = 1'b0;
        tick(3);
        compared++; if (re_cnt - r0 !== 1) begin mismatched++; $display("FAIL single_re_pulses: got %0d want 1", re_cnt - r0); end
        pop_byte(b);
        compared++; if (cpu_rx_count !== 5'd0) begin mismatched++; $display("FAIL single_pop_count: got %0d want 0", cpu_rx_count); end
        compared++; if (cpu_rx_data !== 8'h00) begin mismatched++; $display("FAIL single_pop_data: got %02h want 00", cpu_rx_data); end
        compared++; if (cpu_rx_valid !== 1'b0) begin mismatched++; $display("FAIL single_pop_valid: got %b want 0", cpu_rx_valid); end
    endtask

    task automatic test_fill;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        compared++; if (cpu_rx_count !== 5'd16) begin mismatched++; $display("FAIL fill_count: got %0d want 16", cpu_rx_count); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL fill_no_overrun: got %b want 0", overrun); end
        send_byte(8'h7A);
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL fill_overrun: got %b want 1", overrun); end
        compared++; if (cpu_rx_count !== 5'd16) begin mismatched++; $display("FAIL fill_drop_count: got %0d want 16", cpu_rx_count); end
        for (int i = 0; i < 16; i++) begin
            pop_byte(b);
            compared++; if (b !== 8'h30 + 8'(i)) begin mismatched++; $display("FAIL fill_pop_%0d: got %02h want %02h", i, b, 8'h30 + 8'(i)); end
        end
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL fill_overrun_sticky: got %b want 1", overrun); end
        compared++; if (cpu_rx_valid !== 1'b0) begin mismatched++; $display("FAIL fill_drained: got %b want 0", cpu_rx_valid); end
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL fill_clr_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_full_simul;
        logic [7:0] b;
        logic [7:0] first;
        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
        uart_rx_data  = 8'h55;
        uart_rx_valid = 1'b1;
        cpu_rx_re     = 1'b1;
        first = cpu_rx_data;
        tick(1);
        cpu_rx_re     = 1'b0;
        compared++; if (uart_rx_re !== 1'b1) begin mismatched++; $display("FAIL simul_capture: got %b want 1", uart_rx_re); end
        uart_rx_valid = 1'b0;
        tick(2);
        compared++; if (first !== 8'h60) begin mismatched++; $display("FAIL simul_popped: got %02h want 60", first); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL simul_overrun: got %b want 0", overrun); end
        compared++; if (cpu_rx_count !== 5'd16) begin mismatched++; $display("FAIL simul_count: got %0d want 16", cpu_rx_count); end
        pop_byte(first);
        compared++; if (first !== 8'h61) begin mismatched++; $display("FAIL simul_next_head: got %02h want 61", first); end
        for (int i = 0; i < 15; i++) pop_byte(b);
        compared++; if (b !== 8'h55) begin mismatched++; $display("FAIL simul_last: got %02h want 55", b); end
        compared++; if (cpu_rx_count !== 5'd0) begin mismatched++; $display("FAIL simul_drained: got %0d want 0", cpu_rx_count); end
    endtask

    task automatic test_stuck;
        logic [7:0] b;
        int r0;
        r0 = re_cnt;
        uart_rx_data  = 8'h21;
        uart_rx_valid = 1'b1;
        tick(10);
        uart_rx_valid = 1'b0;
        tick(3);
        compared++; if (re_cnt - r0 !== 1) begin mismatched++; $display("FAIL stuck_re_pulses: got %0d want 1", re_cnt - r0); end
        compared++; if (cpu_rx_count !== 5'd1) begin mismatched++; $display("FAIL stuck_count: got %0d want 1", cpu_rx_count); end
        compared++; if (cpu_rx_data !== 8'h21) begin mismatched++; $display("FAIL stuck_data: got %02h want 21", cpu_rx_data); end
        pop_byte(b);
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        uart_rx_data  = 8'h05;
        uart_rx_valid = 1'b1;
        tick(1);
        compared++; if (cpu_rx_count !== 5'd5) begin mismatched++; $display("FAIL rmid_pre_count: got %0d want 5", cpu_rx_count); end
        #2;
        resetn = 1'b0;
        #1;
        compared++; if (uart_rx_re !== 1'b0) begin mismatched++; $display("FAIL rmid_rx_re: got %b want 0", uart_rx_re); end
        compared++; if (cpu_rx_count !== 5'd0) begin mismatched++; $display("FAIL rmid_count: got %0d want 0", cpu_rx_count); end
        compared++; if (cpu_rx_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: got %b want 0", cpu_rx_valid); end
        compared++; if (cpu_rx_data !== 8'h00) begin mismatched++; $display("FAIL rmid_data: got %02h want 00", cpu_rx_data); end
        uart_rx_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick(1);
        send_byte(8'h42);
        compared++; if (cpu_rx_count !== 5'd1) begin mismatched++; $display("FAIL rmid_new_count: got %0d want 1", cpu_rx_count); end
        compared++; if (cpu_rx_data !== 8'h42) begin mismatched++; $display("FAIL rmid_new_data: got %02h want 42", cpu_rx_data); end
        pop_byte(b);
    endtask

    task automatic test_tx;
        logic [7:0] b;
        int t0;
        int t1;
`ifdef UART_RX_ECHO_EN
        t0 = tx_cnt;
        uart_tx_busy  = 1'b0;
        cpu_tx_data   = 8'h2A;
        cpu_tx_we     = 1'b1;
        uart_rx_data  = 8'h68;
        uart_rx_valid = 1'b1;
        tick(1);
        compared++; if (uart_tx_we !== 1'b1) begin mismatched++; $display("FAIL echo_cpu_we: got %b want 1", uart_tx_we); end
        compared++; if (uart_tx_data !== 8'h2A) begin mismatched++; $display("FAIL echo_cpu_data: got %02h want 2A", uart_tx_data); end
        cpu_tx_we     = 1'b0;
        uart_tx_busy  = 1'b1;
        uart_rx_valid = 1'b0;
        tick(4);
        compared++; if (tx_cnt - t0 !== 1) begin mismatched++; $display("FAIL echo_wait_busy: got %0d strobes want 1", tx_cnt - t0); end
        uart_tx_busy = 1'b0;
        t1 = tx_cnt;
        tick(4);
        compared++; if (tx_cnt - t1 !== 1) begin mismatched++; $display("FAIL echo_pulses: got %0d want 1", tx_cnt - t1); end
        compared++; if (tx_last !== 8'h68) begin mismatched++; $display("FAIL echo_data: got %02h want 68", tx_last); end
`else
        t0 = tx_cnt;
        cpu_tx_data = 8'hA5;
        cpu_tx_we   = 1'b1;
        #1;
        compared++; if (uart_tx_we !== 1'b1) begin mismatched++; $display("FAIL pass_we: got %b want 1", uart_tx_we); end
        compared++; if (uart_tx_data !== 8'hA5) begin mismatched++; $display("FAIL pass_data: got %02h want A5", uart_tx_data); end
        cpu_tx_we   = 1'b0;
        cpu_tx_data = 8'h3C;
        #1;
        compared++; if (uart_tx_we !== 1'b0) begin mismatched++; $display("FAIL pass_we_low: got %b want 0", uart_tx_we); end
        compared++; if (uart_tx_data !== 8'h3C) begin mismatched++; $display("FAIL pass_data2: got %02h want 3C", uart_tx_data); end
        tick(1);
        t1 = tx_cnt;
        send_byte(8'h68);
        tick(3);
        compared++; if (tx_cnt - t1 !== 0) begin mismatched++; $display("FAIL pass_no_echo: got %0d strobes want 0", tx_cnt - t1); end
        compared++; if (t1 - t0 !== 0) begin mismatched++; $display("FAIL pass_no_stray: got %0d strobes want 0", t1 - t0); end
`endif
        pop_byte(b);
        compared++; if (b !== 8'h68) begin mismatched++; $display("FAIL tx_rx_byte: got %02h want 68", b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_stuck();
        test_reset_mid();
        test_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
